// File: rtl/coherence_bus_ctrl_rr.sv
// Round-robin MSI/E snoop bus controller between CPUS private L1 caches and
// a shared L2 port. Serialises coherence transactions; each one resolves by
// cache-to-cache snoop, L2 fill, L2 writeback or invalidate-upgrade.
module coherence_bus_ctrl_rr #(
  parameter int CPUS       = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int ADDR_W     = 32
) (
  input  logic                               clk,
  input  logic                               nRST,
  input  logic [CPUS-1:0]                    dREN,
  input  logic [CPUS-1:0]                    dWEN,
  input  logic [CPUS*ADDR_W-1:0]             daddr,
  input  logic [CPUS*32*BLOCK_SIZE-1:0]      dstore,
  input  logic [CPUS-1:0]                    cctrans,
  input  logic [CPUS-1:0]                    ccwrite,
  input  logic [CPUS-1:0]                    ccsnoophit,
  input  logic [CPUS-1:0]                    ccsnoopdone,
  input  logic [CPUS-1:0]                    ccdirty,
  output logic [CPUS-1:0]                    dwait,
  output logic [CPUS*32*BLOCK_SIZE-1:0]      dload,
  output logic [CPUS-1:0]                    ccwait,
  output logic [CPUS-1:0]                    ccinv,
  output logic [CPUS-1:0]                    ccexclusive,
  output logic [ADDR_W-1:0]                  ccsnoopaddr,
  output logic                               l2REN,
  output logic                               l2WEN,
  output logic [ADDR_W-1:0]                  l2addr,
  output logic [32*BLOCK_SIZE-1:0]           l2store,
  input  logic [32*BLOCK_SIZE-1:0]           l2load,
  input  logic                               l2ready
);

  localparam int DW = 32 * BLOCK_SIZE;
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_WB_L2, S_READ_L2, S_WRITEBACK, S_INVALIDATE, S_DONE
  } state_t;

  typedef enum logic [1:0] {C_WB, C_RD, C_RX, C_UPG} cls_t;

  state_t            state_reg, state_next;
  cls_t              cls_reg;
  logic [IW-1:0]     ptr_reg, req_reg, hitter_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CPUS-1:0]   done_reg;
  logic              hit_reg, hdirty_reg;
  logic [DW-1:0]     hdata_reg;
  logic [CPUS*DW-1:0] dload_reg;

  logic [CPUS-1:0]   is_wb, is_rd, is_upg, any_req;
  logic [ADDR_W-1:0] addr_arr [CPUS];
  logic [DW-1:0]     store_arr [CPUS];

  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic [CPUS-1:0]   req_onehot;
  logic              all_done;
  logic              new_hit_valid;
  logic [IW-1:0]     new_hit_idx;
  logic [DW-1:0]     fill_data;

  // Per-CPU request decode and bus slicing
  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_cpu
      assign is_wb[gi]     = dWEN[gi];
      assign is_rd[gi]     = dREN[gi] & cctrans[gi];
      assign is_upg[gi]    = ccwrite[gi] & ~cctrans[gi] & dREN[gi];
      assign any_req[gi]   = is_wb[gi] | is_rd[gi] | is_upg[gi];
      assign addr_arr[gi]  = daddr[gi*ADDR_W +: ADDR_W];
      assign store_arr[gi] = dstore[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search starting just after the last winner
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = CPUS; k >= 1; k--) begin
      if (any_req[(int'(ptr_reg) + k) % CPUS]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(ptr_reg) + k) % CPUS);
      end
    end
  end

  // Lowest-index non-requester reporting a hit with its response this cycle
  always_comb begin
    req_onehot          = '0;
    req_onehot[req_reg] = 1'b1;
    new_hit_valid       = 1'b0;
    new_hit_idx         = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (ccsnoopdone[j] && ccsnoophit[j] && !req_onehot[j]) begin
        new_hit_valid = 1'b1;
        new_hit_idx   = IW'(j);
      end
    end
    // Decision waits for the sticky vector so dones may arrive on any cycles
    all_done  = &(done_reg | req_onehot);
    fill_data = (state_reg == S_READ_L2) ? l2load : hdata_reg;
  end

  // Next-state logic and bus outputs
  always_comb begin
    state_next  = state_reg;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccexclusive = '0;
    ccsnoopaddr = '0;
    l2REN       = 1'b0;
    l2WEN       = 1'b0;
    l2addr      = '0;
    l2store     = '0;
    case (state_reg)
      S_IDLE: begin
        if (grant_valid) begin
          if (is_wb[grant_idx])      state_next = S_WRITEBACK;
          else if (is_rd[grant_idx]) state_next = S_SNOOP;
          else                       state_next = S_INVALIDATE;
        end
      end
      S_SNOOP: begin
        ccsnoopaddr = addr_reg;
        ccwait      = ~req_onehot;
        if (cls_reg == C_RX) ccinv = ~req_onehot;
        if (all_done) begin
          if (!hit_reg)                              state_next = S_READ_L2;
          else if (cls_reg == C_RD && hdirty_reg)    state_next = S_WB_L2;
          else                                       state_next = S_DONE;
        end
      end
      S_WB_L2: begin
        l2WEN   = 1'b1;
        l2addr  = addr_reg;
        l2store = hdata_reg;
        if (l2ready) state_next = S_DONE;
      end
      S_READ_L2: begin
        l2REN  = 1'b1;
        l2addr = addr_reg;
        if (l2ready) state_next = S_DONE;
      end
      S_WRITEBACK: begin
        l2WEN   = 1'b1;
        l2addr  = addr_reg;
        l2store = store_arr[req_reg];
        if (l2ready) state_next = S_DONE;
      end
      S_INVALIDATE: begin
        ccsnoopaddr = addr_reg;
        ccwait      = ~req_onehot;
        ccinv       = ~req_onehot;
        if (all_done) state_next = S_DONE;
      end
      S_DONE: begin
        dwait[req_reg] = 1'b0;
        ccexclusive[req_reg] = (cls_reg == C_RX) || (cls_reg == C_UPG) ||
                               (cls_reg == C_RD && !hit_reg);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign dload = dload_reg;

  // State, latched request, snoop bookkeeping and registered fill data
  always_ff @(posedge clk) begin
    if (nRST) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= IW'(CPUS - 1);
      req_reg    <= '0;
      addr_reg   <= '0;
      cls_reg    <= C_WB;
      done_reg   <= '0;
      hit_reg    <= 1'b0;
      hitter_reg <= '0;
      hdirty_reg <= 1'b0;
      hdata_reg  <= '0;
      dload_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dload_reg <= '0;
      if (state_reg == S_IDLE && grant_valid) begin
        ptr_reg    <= grant_idx;
        req_reg    <= grant_idx;
        addr_reg   <= addr_arr[grant_idx];
        done_reg   <= '0;
        hit_reg    <= 1'b0;
        hitter_reg <= '0;
        hdirty_reg <= 1'b0;
        hdata_reg  <= '0;
        if (is_wb[grant_idx])        cls_reg <= C_WB;
        else if (is_rd[grant_idx])   cls_reg <= ccwrite[grant_idx] ? C_RX : C_RD;
        else                         cls_reg <= C_UPG;
      end
      if (state_reg == S_SNOOP || state_reg == S_INVALIDATE)
        done_reg <= done_reg | (ccsnoopdone & ~req_onehot);
      if (state_reg == S_SNOOP && new_hit_valid &&
          (!hit_reg || new_hit_idx < hitter_reg)) begin
        hit_reg    <= 1'b1;
        hitter_reg <= new_hit_idx;
        hdirty_reg <= ccdirty[new_hit_idx];
        hdata_reg  <= store_arr[new_hit_idx];
      end
      if (state_next == S_DONE && state_reg != S_DONE)
        dload_reg[int'(req_reg)*DW +: DW] <= fill_data;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl_rr.sv
// Scoreboard bench for coherence_bus_ctrl_rr: stimulus pushes expected
// completions and L2 operations; a negedge monitor pops and compares.
module tb_coherence_bus_ctrl_rr;

  localparam int CPUS = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic nRST;
  logic [CPUS-1:0] dREN, dWEN, cctrans, ccwrite, ccsnoophit, ccsnoopdone, ccdirty;
  logic [CPUS*AW-1:0] daddr;
  logic [CPUS*DW-1:0] dstore;
  logic [CPUS-1:0] dwait, ccwait, ccinv, ccexclusive;
  logic [CPUS*DW-1:0] dload;
  logic [AW-1:0] ccsnoopaddr, l2addr;
  logic l2REN, l2WEN, l2ready;
  logic [DW-1:0] l2store, l2load;

  always #5 clk = ~clk;

  coherence_bus_ctrl_rr #(.CPUS(CPUS), .BLOCK_SIZE(2), .ADDR_W(AW)) dut (
    .clk(clk), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccsnoophit(ccsnoophit), .ccsnoopdone(ccsnoopdone), .ccdirty(ccdirty),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccexclusive(ccexclusive), .ccsnoopaddr(ccsnoopaddr), .l2REN(l2REN),
    .l2WEN(l2WEN), .l2addr(l2addr), .l2store(l2store), .l2load(l2load),
    .l2ready(l2ready)
  );

  typedef struct { int cpu; logic [DW-1:0] data; logic excl; } comp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } l2wr_t;
  typedef struct { logic [AW-1:0] addr; int cycles; } l2rd_t;

  comp_t comp_q[$];
  l2wr_t l2wr_q[$];
  l2rd_t l2rd_q[$];

  int checks = 0;
  int errors = 0;
  int l2_lat = 1;
  int resp_cnt = 0;
  int rd_cyc = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    ccsnoophit = '0; ccsnoopdone = '1; ccdirty = '0;
    daddr = '0; dstore = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    cyc();
    cyc();
    nRST = 1'b0;
  endtask

  task automatic wait_comp(input int n);
    int got;
    got = 0;
    for (int c = 0; c < 300 && got < n; c++) begin
      cyc();
      if (dwait != '1) got++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got %0d completions required %0d", got, n);
    end
  endtask

  task automatic push_comp(input int cpu, input logic [DW-1:0] data, input logic excl);
    comp_t e;
    e.cpu = cpu; e.data = data; e.excl = excl;
    comp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] addr, input int cycles);
    l2rd_t e;
    e.addr = addr; e.cycles = cycles;
    l2rd_q.push_back(e);
  endtask

  task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    l2wr_t e;
    e.addr = addr; e.data = data;
    l2wr_q.push_back(e);
  endtask

  // L2 responder: ready on the l2_lat-th cycle of an L2 operation
  initial begin
    l2ready = 1'b0;
    forever begin
      cyc();
      if (nRST || !(l2REN || l2WEN)) begin
        resp_cnt = 0;
        l2ready  = 1'b0;
      end else begin
        resp_cnt++;
        l2ready = (resp_cnt == l2_lat);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a completion or L2 op
  comp_t mon_c;
  l2wr_t mon_w;
  l2rd_t mon_r;
  logic [CPUS-1:0]    mon_dw, mon_ex;
  logic [CPUS*DW-1:0] mon_ld;
  initial begin
    forever begin
      @(negedge clk);
      if (nRST) begin
        rd_cyc = 0;
      end else begin
        if (l2REN || l2WEN) check("l2_exclusive_ops", {l2REN, l2WEN} == 2'b11, 1'b0);
        if (dwait != '1) begin
          if (comp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: dwait=%b required none", dwait);
          end else begin
            mon_c = comp_q.pop_front();
            mon_dw = '1; mon_dw[mon_c.cpu] = 1'b0;
            mon_ld = '0; mon_ld[mon_c.cpu*DW +: DW] = mon_c.data;
            mon_ex = '0; mon_ex[mon_c.cpu] = mon_c.excl;
            check("dwait", dwait, mon_dw);
            check("dload", dload, mon_ld);
            check("ccexclusive", ccexclusive, mon_ex);
          end
        end
        if (l2WEN) begin
          if (l2wr_q.size() > 0) begin
            check("l2wr_addr", l2addr, l2wr_q[0].addr);
            check("l2wr_data", l2store, l2wr_q[0].data);
          end
          if (l2ready) begin
            if (l2wr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_l2_write: addr=%0h required none", l2addr);
            end else begin
              mon_w = l2wr_q.pop_front();
            end
          end
        end
        if (l2REN) begin
          rd_cyc++;
          if (l2rd_q.size() > 0) check("l2rd_addr", l2addr, l2rd_q[0].addr);
          if (l2ready) begin
            if (l2rd_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_l2_read: addr=%0h required none", l2addr);
            end else begin
              mon_r = l2rd_q.pop_front();
              check("l2rd_cycles", rd_cyc, mon_r.cycles);
            end
            rd_cyc = 0;
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    clear_inputs();
    l2load = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_dwait", dwait, 4'hF);
    check("reset_l2REN", l2REN, 1'b0);
    check("reset_l2WEN", l2WEN, 1'b0);
    check("reset_ccwait", ccwait, 4'h0);
    check("reset_ccinv", ccinv, 4'h0);
    check("reset_dload", dload, '0);
    check("reset_ccexcl", ccexclusive, 4'h0);
    cyc();

    // CPU0 read miss, no snoop hit, L2 ready on third READ_L2 cycle
    l2_lat = 3;
    l2load = 64'hA5A5_A5A5_A5A5_A5A5;
    push_rd(32'h100, 3);
    push_comp(0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0*AW +: AW] = 32'h100;
    wait_comp(1);
    clear_inputs(); cyc();

    // CPU1 read, CPU2 dirty hit: write-through to L2 then forward
    l2_lat = 1;
    push_wr(32'h200, 64'h1234_5678_9ABC_DEF0);
    push_comp(1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    dstore[2*DW +: DW] = 64'h1234_5678_9ABC_DEF0;
    ccsnoophit = 4'b0100; ccdirty = 4'b0100;
    dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1*AW +: AW] = 32'h200;
    wait_comp(1);
    clear_inputs(); cyc();

    // CPU3 RX, clean hits in CPU0 and CPU2 with staggered dones
    push_comp(3, 64'h1111_1111_1111_1111, 1'b1);
    dstore[0*DW +: DW] = 64'h1111_1111_1111_1111;
    dstore[2*DW +: DW] = 64'h2222_2222_2222_2222;
    ccsnoophit = 4'b0101; ccsnoopdone = 4'b0000;
    dREN[3] = 1'b1; cctrans[3] = 1'b1; ccwrite[3] = 1'b1; daddr[3*AW +: AW] = 32'h300;
    cyc();
    check("rx_ccinv_0", ccinv, 4'b0111);
    check("rx_ccwait", ccwait, 4'b0111);
    check("rx_snoopaddr", ccsnoopaddr, 32'h300);
    ccsnoopdone = 4'b0011;
    cyc();
    check("rx_ccinv_1", ccinv, 4'b0111);
    ccsnoopdone = 4'b0100;
    cyc();
    check("rx_ccinv_2", ccinv, 4'b0111);
    ccsnoopdone = 4'b0000;
    wait_comp(1);
    clear_inputs(); cyc();

    // All four CPUs request continuously from reset: order 0,1,2,3,0
    do_reset();
    l2_lat = 1;
    l2load = 64'h0F0F_0F0F_0F0F_0F0F;
    for (int j = 0; j < CPUS; j++) daddr[j*AW +: AW] = 32'h1000 + 32'(j) * 32'h10;
    for (int n = 0; n < 5; n++) begin
      push_rd(32'h1000 + 32'(n % CPUS) * 32'h10, 1);
      push_comp(n % CPUS, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    end
    dREN = 4'hF; cctrans = 4'hF;
    wait_comp(5);
    clear_inputs(); cyc();

    // CPU2 eviction writeback, L2 ready after 2 cycles
    l2_lat = 2;
    push_wr(32'h400, 64'hDEAD_BEEF_DEAD_BEEF);
    push_comp(2, 64'h0, 1'b0);
    dWEN[2] = 1'b1; daddr[2*AW +: AW] = 32'h400; dstore[2*DW +: DW] = 64'hDEAD_BEEF_DEAD_BEEF;
    wait_comp(1);
    clear_inputs(); cyc();

    // Reset during READ_L2 abandons the transaction and restarts arbitration
    l2_lat = 1000;
    push_rd(32'h500, 0);
    dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1*AW +: AW] = 32'h500;
    begin
      int c;
      for (c = 0; c < 20 && !l2REN; c++) cyc();
      check("abort_reached_read", l2REN, 1'b1);
    end
    cyc(); cyc();
    nRST = 1'b1;
    clear_inputs();
    l2rd_q.delete();
    cyc();
    check("abort_dwait", dwait, 4'hF);
    check("abort_l2REN", l2REN, 1'b0);
    check("abort_l2WEN", l2WEN, 1'b0);
    nRST = 1'b0;
    l2_lat = 1;
    l2load = 64'h7777_0000_7777_0000;
    push_rd(32'h600, 1); push_comp(0, 64'h7777_0000_7777_0000, 1'b1);
    push_rd(32'h700, 1); push_comp(3, 64'h7777_0000_7777_0000, 1'b1);
    daddr[0*AW +: AW] = 32'h600; daddr[3*AW +: AW] = 32'h700;
    dREN = 4'b1001; cctrans = 4'b1001;
    wait_comp(2);
    clear_inputs();
    repeat (5) cyc();

    check("comp_q_empty", comp_q.size(), 0);
    check("l2wr_q_empty", l2wr_q.size(), 0);
    check("l2rd_q_empty", l2rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
